// File: rtl/mux_8_32_if.sv
// Byte-in / word-out bus of the 8->32 packer.
// The packer takes the slave modport; the byte source and word sink take the master.
interface mux_8_32_if;
    logic [7:0]  data_in;
    logic        valid;
    logic [31:0] data_out;
    logic        valid_out;
    logic        word_stb;
    logic        frag_err;

    modport master (output data_in, valid,
                    input  data_out, valid_out, word_stb, frag_err);
    modport slave  (input  data_in, valid,
                    output data_out, valid_out, word_stb, frag_err);
endinterface

// File: rtl/mux_8_32.sv
// Packs four consecutive valid bytes, MSB first, into a 32-bit word.
// The word is held with valid_out for HOLD cycles. Words broken off mid-assembly raise frag_err.
module mux_8_32 #(
    parameter int HOLD = 4
) (
    input  logic      clk_4f,
    input  logic      reset,
    mux_8_32_if.slave bus
);
    logic [1:0]  sel_q,  sel_d;
    logic [31:0] acc_q,  acc_d;
    logic [31:0] data_q, data_d;
    logic [2:0]  hold_q, hold_d;
    logic        vout_q, vout_d;
    logic        stb_q,  stb_d;
    logic        frag_q, frag_d;

    always_comb begin
        sel_d  = sel_q;
        acc_d  = acc_q;
        data_d = data_q;
        hold_d = hold_q;
        stb_d  = 1'b0;
        frag_d = 1'b0;
        if (bus.valid) begin
            unique case (sel_q)
                2'd0: acc_d[31:24] = bus.data_in;
                2'd1: acc_d[23:16] = bus.data_in;
                2'd2: acc_d[15:8]  = bus.data_in;
                default: begin
                    data_d = {acc_q[31:8], bus.data_in};
                    stb_d  = 1'b1;
                end
            endcase
            sel_d = sel_q + 2'd1;
        end else if (sel_q != 2'd0) begin
            frag_d = 1'b1;
            sel_d  = 2'd0;
            acc_d  = '0;
        end
        // A completion reloads the hold timer even when it would have expired.
        if (stb_d)
            hold_d = 3'(HOLD);
        else if (hold_q != 3'd0)
            hold_d = hold_q - 3'd1;
        vout_d = (hold_d != 3'd0);
    end

    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            sel_q  <= '0;
            acc_q  <= '0;
            data_q <= '0;
            hold_q <= '0;
            vout_q <= 1'b0;
            stb_q  <= 1'b0;
            frag_q <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            acc_q  <= acc_d;
            data_q <= data_d;
            hold_q <= hold_d;
            vout_q <= vout_d;
            stb_q  <= stb_d;
            frag_q <= frag_d;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = vout_q;
    assign bus.word_stb  = stb_q;
    assign bus.frag_err  = frag_q;
endmodule

// File: tb/tb_mux_8_32.sv
// Directed bench for the 8->32 packer.
// One instance uses the default HOLD=4 and a second instance uses HOLD=1.
module tb_mux_8_32;
    logic clk_4f = 1'b0;
    logic reset  = 1'b0;
    int   errors = 0;
    int   checks = 0;

    mux_8_32_if bus0();
    mux_8_32_if bus1();

    mux_8_32            u_dut  (.clk_4f(clk_4f), .reset(reset), .bus(bus0));
    mux_8_32 #(.HOLD(1)) u_dut1 (.clk_4f(clk_4f), .reset(reset), .bus(bus1));

    always #5 clk_4f = ~clk_4f;

    // Each step ends 1 time unit after a rising edge. Outputs then reflect that edge.
    task automatic send(input logic [7:0] b);
        bus0.data_in = b; bus0.valid = 1'b1;
        @(posedge clk_4f); #1;
    endtask

    task automatic send1(input logic [7:0] b);
        bus1.data_in = b; bus1.valid = 1'b1;
        @(posedge clk_4f); #1;
    endtask

    task automatic idle();
        bus0.valid = 1'b0; bus1.valid = 1'b0;
        @(posedge clk_4f); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus0.valid = 1'b0; bus0.data_in = 8'h00;
        bus1.valid = 1'b0; bus1.data_in = 8'h00;
        repeat (2) @(posedge clk_4f);
        #2 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            checks++;
            if ({bus0.data_out, bus0.valid_out, bus0.word_stb, bus0.frag_err} !== 35'h0) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d: got data=%h v=%b stb=%b frag=%b, want all 0",
                         i, bus0.data_out, bus0.valid_out, bus0.word_stb, bus0.frag_err);
            end
        end
    endtask

    task automatic test_single_word();
        send(8'hAA); send(8'hBB); send(8'hCC);
        checks++;
        if (bus0.word_stb !== 1'b0 || bus0.valid_out !== 1'b0) begin
            errors++;
            $display("FAIL single_early: stb=%b v=%b, want 0 0", bus0.word_stb, bus0.valid_out);
        end
        send(8'hDD);
        checks++;
        if (bus0.data_out !== 32'hAABBCCDD || bus0.word_stb !== 1'b1 || bus0.valid_out !== 1'b1) begin
            errors++;
            $display("FAIL single_word: data=%h stb=%b v=%b, want AABBCCDD 1 1",
                     bus0.data_out, bus0.word_stb, bus0.valid_out);
        end
        for (int i = 1; i <= 4; i++) begin
            idle();
            checks++;
            if (bus0.valid_out !== (i < 4) || bus0.word_stb !== 1'b0 || bus0.frag_err !== 1'b0) begin
                errors++;
                $display("FAIL single_hold cyc%0d: v=%b stb=%b frag=%b, want v=%b stb=0 frag=0",
                         i, bus0.valid_out, bus0.word_stb, bus0.frag_err, (i < 4));
            end
        end
        checks++;
        if (bus0.data_out !== 32'hAABBCCDD) begin
            errors++;
            $display("FAIL single_keep: data=%h, want AABBCCDD", bus0.data_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  bytes [12];
        logic [31:0] words [3];
        bytes = '{8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08,8'h09,8'h0A,8'h0B,8'h0C};
        words = '{32'h01020304, 32'h05060708, 32'h090A0B0C};
        for (int i = 0; i < 12; i++) begin
            send(bytes[i]);
            checks++;
            if (bus0.word_stb !== ((i % 4) == 3)) begin
                errors++;
                $display("FAIL b2b_stb byte%0d: got %b, want %b", i, bus0.word_stb, ((i % 4) == 3));
            end
            if ((i % 4) == 3) begin
                checks++;
                if (bus0.data_out !== words[i/4]) begin
                    errors++;
                    $display("FAIL b2b_word%0d: got %h, want %h", i/4, bus0.data_out, words[i/4]);
                end
            end
            if (i >= 3) begin
                checks++;
                if (bus0.valid_out !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_valid byte%0d: got %b, want 1", i, bus0.valid_out);
                end
            end
        end
        for (int i = 1; i <= 4; i++) begin
            idle();
            checks++;
            if (bus0.valid_out !== (i < 4)) begin
                errors++;
                $display("FAIL b2b_tail cyc%0d: v=%b, want %b", i, bus0.valid_out, (i < 4));
            end
        end
    endtask

    task automatic test_fragment();
        send(8'h11); send(8'h22);
        idle();
        checks++;
        if (bus0.frag_err !== 1'b1 || bus0.word_stb !== 1'b0 || bus0.data_out !== 32'h090A0B0C) begin
            errors++;
            $display("FAIL frag_pulse: frag=%b stb=%b data=%h, want 1 0 090A0B0C",
                     bus0.frag_err, bus0.word_stb, bus0.data_out);
        end
        idle();
        checks++;
        if (bus0.frag_err !== 1'b0) begin
            errors++;
            $display("FAIL frag_once: frag=%b, want 0", bus0.frag_err);
        end
        send(8'h44); send(8'h55); send(8'h66); send(8'h77);
        checks++;
        if (bus0.data_out !== 32'h44556677 || bus0.word_stb !== 1'b1) begin
            errors++;
            $display("FAIL frag_next: data=%h stb=%b, want 44556677 1", bus0.data_out, bus0.word_stb);
        end
        repeat (4) idle();
    endtask

    task automatic test_reset_midword();
        send(8'h33); send(8'h44);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({bus0.data_out, bus0.valid_out, bus0.word_stb, bus0.frag_err} !== 35'h0) begin
            errors++;
            $display("FAIL async_reset: data=%h v=%b stb=%b frag=%b, want all 0",
                     bus0.data_out, bus0.valid_out, bus0.word_stb, bus0.frag_err);
        end
        bus0.valid = 1'b0;
        @(posedge clk_4f); #2 reset = 1'b1;
        idle();
        checks++;
        if (bus0.frag_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_nofrag: frag=%b, want 0", bus0.frag_err);
        end
        send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
        checks++;
        if (bus0.data_out !== 32'hA1B2C3D4 || bus0.word_stb !== 1'b1) begin
            errors++;
            $display("FAIL reset_next: data=%h stb=%b, want A1B2C3D4 1", bus0.data_out, bus0.word_stb);
        end
        repeat (4) idle();
    endtask

    task automatic test_hold1();
        for (int w = 0; w < 2; w++) begin
            send1(8'hF0); send1(8'hE1); send1(8'hD2); send1(8'(8'hC3 + w));
            checks++;
            if (bus1.valid_out !== 1'b1 || bus1.data_out !== {24'hF0E1D2, 8'(8'hC3 + w)}) begin
                errors++;
                $display("FAIL hold1_word%0d: v=%b data=%h, want 1 %h", w, bus1.valid_out,
                         bus1.data_out, {24'hF0E1D2, 8'(8'hC3 + w)});
            end
            for (int i = 0; i < 2; i++) begin
                idle();
                checks++;
                if (bus1.valid_out !== 1'b0) begin
                    errors++;
                    $display("FAIL hold1_drop w%0d cyc%0d: v=%b, want 0", w, i, bus1.valid_out);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_fragment();
        test_reset_midword();
        test_hold1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
